local_injector: RTL and testbench

Network-interface transmit engine for one mesh node. It accepts packet requests and payload words from the processing element and serialises them into 17-bit header and body flits on the router's local input port. Flits are only issued when the router's local-full indication allows it. It sits between the PE and the router's `local_data_i` / `local_full_o` pair.

---
 rtl/noc_pkg.sv | 52 +++++
 rtl/inj_payload_fifo.sv | 46 ++++
 rtl/local_injector.sv | 114 +++++++++++
 tb/tb_local_injector.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, field widths and positions, and the
// injector FSM state type. Flit constructors keep the bit layout in one place.
package noc_pkg;

    localparam int FLIT_W    = 17;
    localparam int NODE_ID_W = 4;
    localparam int LEN_W     = 4;
    localparam int PAY_W     = 14;

    // Positions inside the 15-bit flit body (flit bits [14:0])
    localparam int HDR_DEST_LSB  = 11;
    localparam int HDR_SRC_LSB   = 7;
    localparam int HDR_LEN_LSB   = 3;
    localparam int BODY_TAIL_BIT = 14;

    typedef struct packed {
        logic        valid;
        logic        is_header;
        logic [14:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        BODY
    } inj_state_t;

    function automatic flit_t make_header(input logic [NODE_ID_W-1:0] dest,
                                          input logic [NODE_ID_W-1:0] src,
                                          input logic [LEN_W-1:0]     len);
        flit_t f;
        f = '0;
        f.valid     = 1'b1;
        f.is_header = 1'b1;
        f.payload[HDR_DEST_LSB +: NODE_ID_W] = dest;
        f.payload[HDR_SRC_LSB  +: NODE_ID_W] = src;
        f.payload[HDR_LEN_LSB  +: LEN_W]     = len;
        return f;
    endfunction

    function automatic flit_t make_body(input logic             tail,
                                        input logic [PAY_W-1:0] pay);
        flit_t f;
        f = '0;
        f.valid     = 1'b1;
        f.is_header = 1'b0;
        f.payload[BODY_TAIL_BIT] = tail;
        f.payload[PAY_W-1:0]     = pay;
        return f;
    endfunction

endpackage

// File: rtl/inj_payload_fifo.sv
// Synchronous payload FIFO with full/empty flags; pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
module inj_payload_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/local_injector.sv
// Mesh-node transmit engine: serialises PE requests and payload words into
// header/body flits for the router local port. Optional LOCAL_INJECTOR_STATS_EN adds pkt_count_o.
module local_injector
    import noc_pkg::*;
#(
    parameter int NODE_ID    = 13,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [NODE_ID_W-1:0] req_dest_i,
    input  logic [LEN_W-1:0]     req_len_i,
    input  logic                 pay_valid_i,
    input  logic [PAY_W-1:0]     pay_i,
    output logic                 pay_ready_o,
    input  logic                 local_full_i,
    output logic [FLIT_W-1:0]    local_data_o,
    output logic                 busy_o,
    output logic                 pkt_sent_o
`ifdef LOCAL_INJECTOR_STATS_EN
    ,
    output logic [15:0]          pkt_count_o
`endif
);
    localparam logic [NODE_ID_W-1:0] SRC_ID = NODE_ID_W'(NODE_ID);

    inj_state_t           state;
    logic [NODE_ID_W-1:0] dest_q;
    logic [LEN_W-1:0]     rem_q;
    logic [PAY_W-1:0]     fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 issue_body;

    assign issue_body  = (state == BODY) && !local_full_i && !fifo_empty;
    assign pay_ready_o = !fifo_full;
    assign busy_o      = (state != IDLE);

    inj_payload_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (pay_valid_i),
        .wdata (pay_i),
        .pop   (issue_body),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // req_ready_o is held low through the final-flit cycle and only rises on
    // the following edge, so the next request cannot overlap the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            dest_q       <= '0;
            rem_q        <= '0;
            req_ready_o  <= 1'b1;
            local_data_o <= '0;
            pkt_sent_o   <= 1'b0;
        end else begin
            local_data_o <= '0;
            pkt_sent_o   <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        dest_q      <= req_dest_i;
                        rem_q       <= req_len_i;
                        req_ready_o <= 1'b0;
                        state       <= HDR;
                    end
                end
                HDR: begin
                    if (!local_full_i) begin
                        local_data_o <= make_header(dest_q, SRC_ID, rem_q);
                        if (rem_q == '0) begin
                            pkt_sent_o <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (issue_body) begin
                        local_data_o <= make_body(rem_q == LEN_W'(1), fifo_rdata);
                        rem_q        <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            pkt_sent_o <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOCAL_INJECTOR_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count_o <= '0;
        end else if (pkt_sent_o) begin
            pkt_count_o <= pkt_count_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_local_injector.sv
// Self-checking bench for local_injector: directed literal scenarios plus a
// randomized phase, all checked every cycle against a queue-based packet model.
module tb_local_injector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_dest_i = '0;
    logic [3:0]  req_len_i = '0;
    logic        pay_valid_i = 1'b0;
    logic [13:0] pay_i = '0;
    logic        pay_ready_o;
    logic        local_full_i = 1'b0;
    logic [16:0] local_data_o;
    logic        busy_o;
    logic        pkt_sent_o;
`ifdef LOCAL_INJECTOR_STATS_EN
    logic [15:0] pkt_count_o;
`endif

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    local_injector #(
        .NODE_ID    (13),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_dest_i   (req_dest_i),
        .req_len_i    (req_len_i),
        .pay_valid_i  (pay_valid_i),
        .pay_i        (pay_i),
        .pay_ready_o  (pay_ready_o),
        .local_full_i (local_full_i),
        .local_data_o (local_data_o),
        .busy_o       (busy_o),
        .pkt_sent_o   (pkt_sent_o)
`ifdef LOCAL_INJECTOR_STATS_EN
        ,
        .pkt_count_o  (pkt_count_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: one outstanding packet, a word queue, and a one-cycle
    // cooldown after the final flit before the next request may be taken.
    bit          m_active = 1'b0;
    bit          m_hdr_done = 1'b0;
    bit          m_cool = 1'b0;
    logic [3:0]  m_dest = '0;
    logic [3:0]  m_len = '0;
    int          m_left = 0;
    int          q[$];
    logic [16:0] e_data = '0;
    bit          e_sent = 1'b0;
    logic [15:0] m_cnt = '0;

    always @(posedge clk or negedge rst) begin
        bit rdy;
        bit pr;
        bit cool_n;
        int w;
        if (!rst) begin
            m_active = 1'b0;
            m_hdr_done = 1'b0;
            m_cool = 1'b0;
            q.delete();
            e_data = '0;
            e_sent = 1'b0;
            m_cnt = '0;
        end else begin
            rdy = !m_active && !m_cool;
            pr = (q.size() < 8);
            cool_n = 1'b0;
            if (e_sent) m_cnt = m_cnt + 16'd1;
            e_data = '0;
            e_sent = 1'b0;
            if (m_active && !local_full_i) begin
                if (!m_hdr_done) begin
                    e_data = {1'b1, 1'b1, m_dest, 4'd13, m_len, 3'b000};
                    if (m_len == 0) begin
                        e_sent = 1'b1; m_active = 1'b0; cool_n = 1'b1;
                    end else begin
                        m_hdr_done = 1'b1;
                    end
                end else if (q.size() > 0) begin
                    w = q.pop_front();
                    m_left--;
                    e_data = {1'b1, 1'b0, (m_left == 0), w[13:0]};
                    if (m_left == 0) begin
                        e_sent = 1'b1; m_active = 1'b0; cool_n = 1'b1;
                    end
                end
            end
            if (rdy && req_valid_i) begin
                m_active = 1'b1;
                m_hdr_done = 1'b0;
                m_dest = req_dest_i;
                m_len = req_len_i;
                m_left = int'(req_len_i);
            end
            if (pay_valid_i && pr) q.push_back(int'(pay_i));
            m_cool = cool_n;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cycle", {11'd0, local_data_o, pkt_sent_o, req_ready_o, busy_o, pay_ready_o},
                {11'd0, e_data, e_sent, !m_active && !m_cool, m_active, q.size() < 8});
`ifdef LOCAL_INJECTOR_STATS_EN
            chk("pkt_count", {16'd0, pkt_count_o}, {16'd0, m_cnt});
`endif
        end
    end

    task automatic push_word(input logic [13:0] w);
        pay_valid_i = 1'b1;
        pay_i = w;
        @(negedge clk);
        pay_valid_i = 1'b0;
    endtask

    task automatic request(input logic [3:0] d, input logic [3:0] l);
        req_valid_i = 1'b1;
        req_dest_i = d;
        req_len_i = l;
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    logic [16:0] exp3 [4];

    initial begin
        exp3[0] = 17'h19E98; exp3[1] = 17'h10001; exp3[2] = 17'h10002; exp3[3] = 17'h14003;

        repeat (2) @(negedge clk);
        chk("reset_data", {15'd0, local_data_o}, 32'd0);
        chk("reset_flags", {28'd0, req_ready_o, pay_ready_o, busy_o, pkt_sent_o}, 32'b1100);
        rst = 1'b1;
        check_en = 1'b1;
        @(negedge clk);

        // Header-only packet
        request(4'd5, 4'd0);
        chk("hdr_only_ready_drop", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        chk("hdr_only_flit", {15'd0, local_data_o}, 32'h1AE80);
        chk("hdr_only_sent", {31'd0, pkt_sent_o}, 32'd1);
        @(negedge clk);
        chk("hdr_only_ready_back", {31'd0, req_ready_o}, 32'd1);

        // Three-flit packet from a preloaded FIFO
        push_word(14'h0001);
        push_word(14'h0002);
        push_word(14'h0003);
        request(4'd3, 4'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("three_flit_seq", {15'd0, local_data_o}, {15'd0, exp3[i]});
        end
        chk("three_flit_sent", {31'd0, pkt_sent_o}, 32'd1);
        @(negedge clk);

        // Backpressure for 4 cycles after the first body flit
        push_word(14'h0100);
        push_word(14'h0200);
        push_word(14'h0300);
        request(4'd7, 4'd3);
        @(negedge clk);
        chk("bp_header", {15'd0, local_data_o}, 32'h1BE98);
        @(negedge clk);
        chk("bp_body1", {15'd0, local_data_o}, 32'h10100);
        local_full_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_idle", {15'd0, local_data_o}, 32'd0);
        end
        local_full_i = 1'b0;
        @(negedge clk);
        chk("bp_body2", {15'd0, local_data_o}, 32'h10200);
        @(negedge clk);
        chk("bp_tail", {15'd0, local_data_o}, 32'h14300);
        @(negedge clk);

        // FIFO starvation: second word arrives late
        push_word(14'h0011);
        request(4'd2, 4'd2);
        @(negedge clk);
        chk("starve_header", {15'd0, local_data_o}, 32'h19690);
        @(negedge clk);
        chk("starve_body", {15'd0, local_data_o}, 32'h10011);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("starve_idle", {15'd0, local_data_o}, 32'd0);
        end
        push_word(14'h0022);
        chk("starve_wait", {15'd0, local_data_o}, 32'd0);
        @(negedge clk);
        chk("starve_tail", {15'd0, local_data_o}, 32'h14022);
        @(negedge clk);

        // Reset while the header is on the wire, with words still queued
        push_word(14'h0005);
        push_word(14'h0006);
        request(4'd1, 4'd4);
        @(negedge clk);
        chk("rst_pre_header", {15'd0, local_data_o}, 32'h18EA0);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_data", {15'd0, local_data_o}, 32'd0);
        chk("rst_async_flags", {29'd0, req_ready_o, pay_ready_o, busy_o}, 32'b110);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", {31'd0, req_ready_o}, 32'd1);
        pay_valid_i = 1'b1;
        pay_i = 14'h0AAA;
        request(4'd0, 4'd1);
        pay_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_new_header", {15'd0, local_data_o}, 32'h18688);
        @(negedge clk);
        chk("rst_fifo_flushed", {15'd0, local_data_o}, 32'h14AAA);
        @(negedge clk);

        // Randomized traffic with occasional mid-run resets
        for (int c = 0; c < 4000; c++) begin
            local_full_i = ($urandom_range(0, 3) == 0);
            pay_valid_i = ($urandom_range(0, 2) != 0);
            pay_i = 14'($urandom_range(0, 16383));
            req_valid_i = ($urandom_range(0, 3) == 0);
            req_dest_i = 4'($urandom_range(0, 15));
            req_len_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 699) == 0) begin
                #2 rst = 1'b0;
                #1 chk("rand_rst_data", {15'd0, local_data_o}, 32'd0);
                @(negedge clk);
                rst = 1'b1;
            end
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        pay_valid_i = 1'b0;
        local_full_i = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
